// File: rtl/fifo_rr_arbiter_if.sv
// Signal bundle between fifo_rr_arbiter and its two source FIFOs plus the downstream FIFO.
// master = arbiter side, slave = FIFO/environment side.
interface fifo_rr_arbiter_if #(
    parameter int data_width = 6,
    parameter int cnt_width  = 8
);
    logic                  empty_D0;
    logic                  empty_D1;
    logic [data_width-1:0] data_in_D0;
    logic [data_width-1:0] data_in_D1;
    logic                  full_out;
    logic                  almost_full_out;
    logic                  pop_D0;
    logic                  pop_D1;
    logic                  push_out;
    logic [data_width-1:0] data_out;
    logic [cnt_width-1:0]  cnt_D0;
    logic [cnt_width-1:0]  cnt_D1;

    modport master (
        input  empty_D0, empty_D1, data_in_D0, data_in_D1, full_out, almost_full_out,
        output pop_D0, pop_D1, push_out, data_out, cnt_D0, cnt_D1
    );

    modport slave (
        output empty_D0, empty_D1, data_in_D0, data_in_D1, full_out, almost_full_out,
        input  pop_D0, pop_D1, push_out, data_out, cnt_D0, cnt_D1
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain of two source FIFOs into one downstream FIFO, with saturating per-source counters.
// Define FIFO_ARB_STRICT_PRIO_EN to give D0 strict priority instead of round-robin.
module fifo_rr_arbiter #(
    parameter int data_width = 6,
    parameter int cnt_width  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_rr_arbiter_if.master    bus
);
    typedef enum logic {
        LAST_D0 = 1'b0,
        LAST_D1 = 1'b1
    } last_t;

    last_t                last_grant_reg;
    logic                 inflight_reg;
    logic                 sel_reg;
    logic [cnt_width-1:0] cnt_reg [2];

    logic room;
    logic grant_d0;
    logic grant_d1;

    // A word already in flight will land next cycle, so almost-full leaves no room for another.
    assign room = !bus.full_out && !(bus.almost_full_out && inflight_reg);

    always_comb begin
        grant_d0 = 1'b0;
        grant_d1 = 1'b0;
        if (reset && room) begin
`ifdef FIFO_ARB_STRICT_PRIO_EN
            if (!bus.empty_D0) begin
                grant_d0 = 1'b1;
            end else if (!bus.empty_D1) begin
                grant_d1 = 1'b1;
            end
`else
            if (!bus.empty_D0 && !bus.empty_D1) begin
                if (last_grant_reg == LAST_D1) begin
                    grant_d0 = 1'b1;
                end else begin
                    grant_d1 = 1'b1;
                end
            end else if (!bus.empty_D0) begin
                grant_d0 = 1'b1;
            end else if (!bus.empty_D1) begin
                grant_d1 = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_reg <= LAST_D1;
            inflight_reg   <= 1'b0;
            sel_reg        <= 1'b0;
        end else begin
            inflight_reg <= grant_d0 || grant_d1;
            if (grant_d0) begin
                last_grant_reg <= LAST_D0;
                sel_reg        <= 1'b0;
            end else if (grant_d1) begin
                last_grant_reg <= LAST_D1;
                sel_reg        <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg[gi] <= '0;
                end else if (inflight_reg && (sel_reg == 1'(gi)) && (cnt_reg[gi] != '1)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign bus.pop_D0   = grant_d0;
    assign bus.pop_D1   = grant_d1;
    assign bus.push_out = inflight_reg;
    assign bus.data_out = inflight_reg ? (sel_reg ? bus.data_in_D1 : bus.data_in_D0) : '0;
    assign bus.cnt_D0   = cnt_reg[0];
    assign bus.cnt_D1   = cnt_reg[1];
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter: source FIFOs are modelled as arrays with registered read data.
`timescale 1ns/1ps
module tb_fifo_rr_arbiter;
    localparam int DW = 6;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fifo_rr_arbiter_if #(.data_width(DW), .cnt_width(CW)) bus ();

    fifo_rr_arbiter #(.data_width(DW), .cnt_width(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem0 [0:511];
    logic [DW-1:0] mem1 [0:511];
    int loaded0 = 0, loaded1 = 0;
    int popped0 = 0, popped1 = 0;
    logic [DW-1:0] exp_q [$];

    assign bus.empty_D0 = (loaded0 == popped0);
    assign bus.empty_D1 = (loaded1 == popped1);

    // Source FIFO model: read data registered on the pop edge.
    always @(posedge clk) begin
        if (bus.pop_D0 && (popped0 != loaded0)) begin
            bus.data_in_D0 <= mem0[popped0];
            popped0        <= popped0 + 1;
        end
        if (bus.pop_D1 && (popped1 != loaded1)) begin
            bus.data_in_D1 <= mem1[popped1];
            popped1        <= popped1 + 1;
        end
    end

    task automatic check(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, actual, required);
        end else begin
            $display("ok   %s: 0x%0h", name, actual);
        end
    endtask

    // Monitor: every pushed word is compared against the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.pop_D0 && bus.pop_D1) check("dual_pop", 1, 0);
            if (bus.pop_D0) check("pop_nonempty_D0", int'(bus.empty_D0), 0);
            if (bus.pop_D1) check("pop_nonempty_D1", int'(bus.empty_D1), 0);
            if (bus.push_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_push", int'(bus.data_out), -1);
                end else begin
                    check("push_data", int'(bus.data_out), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic load0(input logic [DW-1:0] v);
        mem0[loaded0] = v;
        loaded0++;
    endtask

    task automatic load1(input logic [DW-1:0] v);
        mem1[loaded1] = v;
        loaded1++;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input string name, input int limit);
        bit done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !bus.push_out && bus.empty_D0 && bus.empty_D1) done = 1'b1;
        end
        check({name, "_drained"}, int'(done), 1);
    endtask

    int pops;

    initial begin
        bus.full_out        = 1'b0;
        bus.almost_full_out = 1'b0;
        bus.data_in_D0      = '0;
        bus.data_in_D1      = '0;

        // Reset state
        #1;
        check("rst_push", int'(bus.push_out), 0);
        check("rst_pop", int'({bus.pop_D0, bus.pop_D1}), 0);
        check("rst_data", int'(bus.data_out), 0);
        check("rst_cnt", int'({bus.cnt_D0, bus.cnt_D1}), 0);
        reset_dut();

        // D0 only, three words: pop immediately, push one cycle later
        load0(6'h01); load0(6'h02); load0(6'h03);
        exp_q.push_back(6'h01); exp_q.push_back(6'h02); exp_q.push_back(6'h03);
        #1;
        check("t1_first_pop", int'({bus.pop_D0, bus.pop_D1}), 2'b10);
        check("t1_no_push_yet", int'(bus.push_out), 0);
        drain("t1", 20);
        check("t1_cnt_D0", int'(bus.cnt_D0), 3);
        check("t1_cnt_D1", int'(bus.cnt_D1), 0);

        // Both sources with four words
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            load0(DW'(6'h10 + i));
            load1(DW'(6'h20 + i));
        end
`ifdef FIFO_ARB_STRICT_PRIO_EN
        for (int i = 0; i < 4; i++) exp_q.push_back(DW'(6'h10 + i));
        for (int i = 0; i < 4; i++) exp_q.push_back(DW'(6'h20 + i));
`else
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(DW'(6'h10 + i));
            exp_q.push_back(DW'(6'h20 + i));
        end
`endif
        drain("t2", 30);
        check("t2_cnt_D0", int'(bus.cnt_D0), 4);
        check("t2_cnt_D1", int'(bus.cnt_D1), 4);

        // Backpressure: almost-full with a word in flight, then full
        reset_dut();
        bus.almost_full_out = 1'b1;
        load0(6'h30); load0(6'h31);
        exp_q.push_back(6'h30); exp_q.push_back(6'h31);
        #1;
        check("bp_first_pop", int'(bus.pop_D0), 1);
        @(negedge clk); #1;
        check("bp_af_inflight", int'(bus.push_out), 1);
        check("bp_af_block", int'(bus.pop_D0), 0);
        bus.full_out = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("bp_full_block", int'(bus.pop_D0), 0);
        bus.full_out        = 1'b0;
        bus.almost_full_out = 1'b0;
        #1;
        check("bp_resume", int'(bus.pop_D0), 1);
        drain("bp", 20);

        // Full held throughout: nothing may be popped
        bus.full_out = 1'b1;
        load1(6'h2A); load1(6'h2B);
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            pops += int'(bus.pop_D0) + int'(bus.pop_D1);
            @(negedge clk);
        end
        check("full_zero_pops", pops, 0);
        exp_q.push_back(6'h2A); exp_q.push_back(6'h2B);
        bus.full_out = 1'b0;
        drain("full", 20);

        // Asynchronous reset between pop and push drops the in-flight word
        reset_dut();
        load0(6'h3F);
        @(posedge clk); #1;
        check("ar_inflight", int'(bus.push_out), 1);
        #1 reset = 1'b0;
        #1;
        check("ar_push_drop", int'(bus.push_out), 0);
        check("ar_cnt", int'({bus.cnt_D0, bus.cnt_D1}), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        check("ar_no_push_after", int'(bus.push_out), 0);

        // Counter saturation: 257 D0 words drive cnt_D0 past 0xFF
        reset_dut();
        for (int i = 0; i < 257; i++) begin
            load0(DW'(i));
            exp_q.push_back(DW'(i));
        end
        drain("sat", 400);
        check("sat_cnt_D0", int'(bus.cnt_D0), 255);
        check("sat_cnt_D1", int'(bus.cnt_D1), 0);

        // Two words per source
        reset_dut();
        load0(6'h05); load0(6'h06);
        load1(6'h25); load1(6'h26);
`ifdef FIFO_ARB_STRICT_PRIO_EN
        exp_q.push_back(6'h05); exp_q.push_back(6'h06);
        exp_q.push_back(6'h25); exp_q.push_back(6'h26);
`else
        exp_q.push_back(6'h05); exp_q.push_back(6'h25);
        exp_q.push_back(6'h06); exp_q.push_back(6'h26);
`endif
        drain("two", 20);
        check("two_cnt", int'({bus.cnt_D0, bus.cnt_D1}), {8'd2, 8'd2});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Downstream consumer of the two per-class transmit FIFOs (D0, D1). Pops one word per cycle from whichever FIFO is non-empty, using round-robin fairness, and pushes it into a single downstream FIFO. Respects downstream full/almost-full backpressure, accounting for the one word in flight caused by the FIFOs' registered read data. Keeps saturating per-source word counters for debug.

## Interface
- data_width, 6, word width; matches the source FIFOs.
- cnt_width, 8, width of each per-source forwarded-word counter.

- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; asserting forces all state and outputs to reset values immediately.
- empty_D0, empty_D1  in  1  empty flags of the source FIFOs.
- data_in_D0, data_in_D1  in  data_width  registered read data of the source FIFOs; valid the cycle after the matching pop.
- full_out, almost_full_out  in  1  flags of the downstream FIFO.
- pop_D0, pop_D1  out  1  read enables to the source FIFOs; at most one high per cycle.
- push_out  out  1  write enable to the downstream FIFO.
- data_out  out  data_width  word to the downstream FIFO.
- cnt_D0, cnt_D1  out  cnt_width  words forwarded from each source; saturate at all-ones.

## Operation
- Registered state: last_grant (LAST_D0 / LAST_D1), inflight (pop issued last cycle), sel_q (source of in-flight word), cnt_D0, cnt_D1.
- Reset values: last_grant = LAST_D1 (D0 wins first tie), inflight = 0, sel_q = 0, counters = 0. Outputs are pop_D0 = pop_D1 = 0, push_out = 0 and data_out = 0.
- room = !full_out && !(almost_full_out && inflight).
- Grant, combinational from flags and state:
  - no grant if !room or both FIFOs are empty;
  - if exactly one FIFO is non-empty, grant it;
  - if both are non-empty, grant the source that is not last_grant.
- On grant:
  - assert the matching pop;
  - next edge: last_grant updates, sel_q = granted source, inflight = 1.
- No grant: inflight = 0 next edge; last_grant and sel_q hold.
- push_out = inflight.
- data_out = sel_q ? data_in_D1 : data_in_D0 while inflight, otherwise 0.
- Counter of the source whose word is pushed increments on the edge at which push_out is high. It holds at 2^cnt_width-1.
- Never pops an empty FIFO; the source FIFOs do not guard underflow.

## Timing
- Pop at cycle t → push_out and data_out valid in cycle t+1 (latency 1); the downstream FIFO samples them at the end of t+1.
- Sustained throughput: one word per cycle.
- With both sources continuously non-empty, grants alternate D0, D1, D0, …
- Source empty flags update at the edge following a pop. Back-to-back pops from the same FIFO holding exactly one word never occur: the pop of the last word sets empty before the next grant decision.
- Backpressure:
  - almost_full_out with a word in flight blocks the pop in that cycle;
  - full_out always blocks.
- Reset asserted mid-transfer: the in-flight word is dropped and push_out deasserts at once. After release, the first grant may occur in the first cycle.

## Configuration
- FIFO_ARB_STRICT_PRIO_EN defined: D0 has strict priority, so D1 is granted only when empty_D0 = 1. last_grant is still maintained but ignored for the grant decision.
- Undefined (default): round-robin as described above.

## Test plan
- After reset: D0 holds 3 words (0x01, 0x02, 0x03) and D1 is empty. Required: pop_D0 high for cycles 1–3 with nothing else; push_out high for cycles 2–4 with data_out 0x01, 0x02, 0x03; cnt_D0 = 3.
- Both FIFOs hold 4 words (D0 0x10.., D1 0x20..). Required: pops alternate D0, D1 for 8 cycles; output order 0x10, 0x20, 0x11, 0x21, …; cnt_D0 = cnt_D1 = 4.
- almost_full_out = 1 while a word is in flight. Required: no pop that cycle; pop resumes the cycle after full_out and almost_full_out both drop. full_out = 1 throughout: zero pops.
- Reset asserted asynchronously between a pop and its push. Required: push_out falls with no clock edge; counters read 0; no push in the next cycle.
- Force cnt_D0 to 0xFE, then forward 3 D0 words. Required: cnt_D0 = 0xFF and stays there.
- With FIFO_ARB_STRICT_PRIO_EN defined and both FIFOs holding 2 words: output order is D0, D0, D1, D1.
